// File: rtl/usb_cmd_pkg.sv
// Shared constants and types for the USB command frame parser.
// Sync bytes, known command codes and the parser state encoding.
package usb_cmd_pkg;

  localparam logic [7:0] USB_HDR0 = 8'hAA;
  localparam logic [7:0] USB_HDR1 = 8'h55;

  localparam logic [7:0] CMD_I2C_CONFIG = 8'h04;
  localparam logic [7:0] CMD_I2C_WRITE  = 8'h05;
  localparam logic [7:0] CMD_I2C_READ   = 8'h06;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC1,
    ST_CMD,
    ST_LEN_H,
    ST_LEN_L,
    ST_PAYLOAD,
    ST_CSUM
  } parser_state_e;

endpackage

// File: rtl/inter_byte_timer.sv
// Inter-byte gap counter: expire_o is a combinational 1-cycle pulse on the TIMEOUT_CYCLES-th idle cycle.
// No backpressure; clear_i wins over enable_i, counter holds while disabled.
module inter_byte_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/usb_cmd_frame_parser.sv
// Frame parser for AA 55 cmd lenH lenL payload checksum; all outputs registered, pulses 1 cycle after the sampled byte.
// No backpressure: one byte per cycle max, frames abort on oversize length or inter-byte timeout.
module usb_cmd_frame_parser
  import usb_cmd_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD    = 128,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  HDR0           = USB_HDR0,
  parameter logic [7:0]  HDR1           = USB_HDR1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  usb_data_in,
  input  logic        usb_data_valid_in,
  output logic [7:0]  cmd_type_out,
  output logic [15:0] cmd_length_out,
  output logic        cmd_start_out,
  output logic [7:0]  cmd_data_out,
  output logic [15:0] cmd_data_index_out,
  output logic        cmd_data_valid_out,
  output logic        cmd_done_out,
  output logic        cmd_error_out,
  output logic        parser_busy_out
);

  parser_state_e state_q;
  logic [7:0]    csum_q;
  logic [15:0]   cnt_q;
  logic [7:0]    type_q;
  logic [7:0]    len_hi_q;
  logic [15:0]   rx_len;
  logic          tmr_clear;
  logic          tmr_expire;

  assign rx_len    = {len_hi_q, usb_data_in};
  assign tmr_clear = usb_data_valid_in || (state_q == ST_IDLE) || tmr_expire;

  inter_byte_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (tmr_clear),
    .enable_i(state_q != ST_IDLE),
    .expire_o(tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= ST_IDLE;
      csum_q             <= '0;
      cnt_q              <= '0;
      type_q             <= '0;
      len_hi_q           <= '0;
      cmd_type_out       <= '0;
      cmd_length_out     <= '0;
      cmd_start_out      <= 1'b0;
      cmd_data_out       <= '0;
      cmd_data_index_out <= '0;
      cmd_data_valid_out <= 1'b0;
      cmd_done_out       <= 1'b0;
      cmd_error_out      <= 1'b0;
      parser_busy_out    <= 1'b0;
    end else begin
      cmd_start_out      <= 1'b0;
      cmd_data_valid_out <= 1'b0;
      cmd_done_out       <= 1'b0;
      cmd_error_out      <= 1'b0;
      // Timeout has priority: a byte landing on the expiry cycle is dropped.
      if (tmr_expire) begin
        cmd_error_out   <= 1'b1;
        state_q         <= ST_IDLE;
        parser_busy_out <= 1'b0;
      end else if (usb_data_valid_in) begin
        case (state_q)
          ST_IDLE: begin
            if (usb_data_in == HDR0) begin
              state_q         <= ST_SYNC1;
              parser_busy_out <= 1'b1;
            end
          end
          ST_SYNC1: begin
            if (usb_data_in == HDR1) begin
              state_q <= ST_CMD;
            end else if (usb_data_in != HDR0) begin
              state_q         <= ST_IDLE;
              parser_busy_out <= 1'b0;
            end
          end
          ST_CMD: begin
            type_q  <= usb_data_in;
            csum_q  <= usb_data_in;
            state_q <= ST_LEN_H;
          end
          ST_LEN_H: begin
            len_hi_q <= usb_data_in;
            csum_q   <= csum_q + usb_data_in;
            state_q  <= ST_LEN_L;
          end
          ST_LEN_L: begin
            if (rx_len > 16'(MAX_PAYLOAD)) begin
              cmd_error_out   <= 1'b1;
              state_q         <= ST_IDLE;
              parser_busy_out <= 1'b0;
            end else begin
              cmd_start_out  <= 1'b1;
              cmd_type_out   <= type_q;
              cmd_length_out <= rx_len;
              csum_q         <= csum_q + usb_data_in;
              cnt_q          <= '0;
              state_q        <= (rx_len == 16'd0) ? ST_CSUM : ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            cmd_data_out       <= usb_data_in;
            cmd_data_index_out <= cnt_q;
            cmd_data_valid_out <= 1'b1;
            csum_q             <= csum_q + usb_data_in;
            cnt_q              <= cnt_q + 16'd1;
            if (cnt_q == cmd_length_out - 16'd1) begin
              state_q <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            if (usb_data_in == csum_q) begin
              cmd_done_out <= 1'b1;
            end else begin
              cmd_error_out <= 1'b1;
            end
            state_q         <= ST_IDLE;
            parser_busy_out <= 1'b0;
          end
          default: begin
            state_q         <= ST_IDLE;
            parser_busy_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_cmd_frame_parser.sv
// Self-checking bench: frames are built from the framing rules and expected events derived arithmetically.
// Directed test-plan frames, boundary lengths, timeout, mid-frame reset, then randomized frames.
module tb_usb_cmd_frame_parser;

  localparam int MAXP = 128;
  localparam int TMO  = 50000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  usb_data_in = '0;
  logic        usb_data_valid_in = 1'b0;
  logic [7:0]  cmd_type_out;
  logic [15:0] cmd_length_out;
  logic        cmd_start_out;
  logic [7:0]  cmd_data_out;
  logic [15:0] cmd_data_index_out;
  logic        cmd_data_valid_out;
  logic        cmd_done_out;
  logic        cmd_error_out;
  logic        parser_busy_out;

  usb_cmd_frame_parser #(.MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk               (clk),
    .rst               (rst),
    .usb_data_in       (usb_data_in),
    .usb_data_valid_in (usb_data_valid_in),
    .cmd_type_out      (cmd_type_out),
    .cmd_length_out    (cmd_length_out),
    .cmd_start_out     (cmd_start_out),
    .cmd_data_out      (cmd_data_out),
    .cmd_data_index_out(cmd_data_index_out),
    .cmd_data_valid_out(cmd_data_valid_out),
    .cmd_done_out      (cmd_done_out),
    .cmd_error_out     (cmd_error_out),
    .parser_busy_out   (parser_busy_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int max_gap = 2;

  logic [7:0]  got_type[$];
  logic [15:0] got_len[$];
  logic [7:0]  got_dat[$];
  logic [15:0] got_idx[$];
  int got_done = 0;
  int got_err  = 0;
  int got_both = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_start_out) begin
        got_type.push_back(cmd_type_out);
        got_len.push_back(cmd_length_out);
      end
      if (cmd_data_valid_out) begin
        got_dat.push_back(cmd_data_out);
        got_idx.push_back(cmd_data_index_out);
      end
      if (cmd_done_out) got_done++;
      if (cmd_error_out) got_err++;
      if (cmd_done_out && cmd_error_out) got_both++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    got_type.delete(); got_len.delete(); got_dat.delete(); got_idx.delete();
    got_done = 0; got_err = 0; got_both = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g;
    usb_data_in = b;
    usb_data_valid_in = 1'b1;
    tick();
    usb_data_valid_in = 1'b0;
    g = $urandom_range(0, max_gap);
    repeat (g) tick();
  endtask

  // pre: bytes sent before the AA 55 header; delta: added to the correct checksum.
  task automatic run_frame(input string tag, input logic [7:0] cmd, input int len,
                           input logic [7:0] pl[$], input int delta, input logic [7:0] pre[$]);
    logic [15:0] l16;
    int sum;
    bit ok;
    l16 = 16'(len);
    clear_obs();
    foreach (pre[i]) send_byte(pre[i]);
    send_byte(8'hAA); send_byte(8'h55); send_byte(cmd);
    send_byte(l16[15:8]); send_byte(l16[7:0]);
    sum = int'(cmd) + int'(l16[15:8]) + int'(l16[7:0]);
    if (len <= MAXP) begin
      foreach (pl[i]) begin
        send_byte(pl[i]);
        sum += int'(pl[i]);
      end
      send_byte(8'((sum + delta) % 256));
    end
    repeat (3) tick();
    ok = (delta % 256) == 0;
    if (len > MAXP) begin
      chk({tag, ":n_start"}, got_type.size(), 0);
      chk({tag, ":n_beats"}, got_dat.size(), 0);
      chk({tag, ":done"}, got_done, 0);
      chk({tag, ":error"}, got_err, 1);
    end else begin
      chk({tag, ":n_start"}, got_type.size(), 1);
      if (got_type.size() > 0) begin
        chk({tag, ":type"}, got_type[0], cmd);
        chk({tag, ":len"}, got_len[0], l16);
      end
      chk({tag, ":n_beats"}, got_dat.size(), len);
      for (int i = 0; i < got_dat.size() && i < len; i++) begin
        chk({tag, ":beat_dat"}, got_dat[i], pl[i]);
        chk({tag, ":beat_idx"}, got_idx[i], i);
      end
      chk({tag, ":done"}, got_done, ok ? 1 : 0);
      chk({tag, ":error"}, got_err, ok ? 0 : 1);
    end
    chk({tag, ":both"}, got_both, 0);
    chk({tag, ":busy_after"}, parser_busy_out, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pl[$];
    logic [7:0] pre[$];
    logic [7:0] b;
    int n;
    int len;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst:type", cmd_type_out, 0);
    chk("rst:len", cmd_length_out, 0);
    chk("rst:start", cmd_start_out, 0);
    chk("rst:dat", cmd_data_out, 0);
    chk("rst:idx", cmd_data_index_out, 0);
    chk("rst:dvld", cmd_data_valid_out, 0);
    chk("rst:done", cmd_done_out, 0);
    chk("rst:err", cmd_error_out, 0);
    chk("rst:busy", parser_busy_out, 0);
    rst = 1'b0;
    tick();

    pre.delete();
    pl = {8'h50};
    run_frame("config", 8'h04, 1, pl, 0, pre);
    pl = {8'h00, 8'h3C, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame("write", 8'h05, 6, pl, 0, pre);
    run_frame("write_badcs", 8'h05, 6, pl, 255, pre);
    pl.delete();
    pre = {8'h12, 8'hAA};
    run_frame("resync", 8'h01, 0, pl, 0, pre);
    pre.delete();
    run_frame("oversize", 8'h05, 129, pl, 0, pre);
    pl = {8'h11, 8'h22};
    run_frame("after_oversize", 8'h06, 2, pl, 0, pre);
    pl.delete();
    for (int i = 0; i < MAXP; i++) pl.push_back(8'($urandom));
    run_frame("len_max", 8'h05, MAXP, pl, 0, pre);

    // Inter-byte timeout after the command byte.
    clear_obs();
    max_gap = 0;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h06);
    n = 0;
    for (int i = 0; i < TMO + 20; i++) begin
      @(negedge clk);
      n++;
      if (got_err != 0) break;
    end
    chk("timeout:window", (n >= TMO - 5 && n <= TMO + 5) ? 1 : 0, 1);
    repeat (4) tick();
    chk("timeout:err_count", got_err, 1);
    chk("timeout:done", got_done, 0);
    chk("timeout:busy", parser_busy_out, 0);

    // Reset in the middle of a payload.
    clear_obs();
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h05);
    send_byte(8'h00); send_byte(8'h06); send_byte(8'h00);
    send_byte(8'h3C); send_byte(8'hDE);
    rst = 1'b1;
    tick();
    chk("midrst:type", cmd_type_out, 0);
    chk("midrst:len", cmd_length_out, 0);
    chk("midrst:dvld", cmd_data_valid_out, 0);
    chk("midrst:idx", cmd_data_index_out, 0);
    chk("midrst:busy", parser_busy_out, 0);
    rst = 1'b0;
    clear_obs();
    repeat (5) tick();
    chk("midrst:done", got_done, 0);
    chk("midrst:err", got_err, 0);
    max_gap = 2;
    pl = {8'h50};
    run_frame("after_rst", 8'h04, 1, pl, 0, pre);

    for (int f = 0; f < 20; f++) begin
      case ($urandom_range(0, 3))
        0: b = 8'h04;
        1: b = 8'h05;
        2: b = 8'h06;
        default: b = 8'($urandom);
      endcase
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(MAXP + 1, 300))
                                         : int'($urandom_range(0, 20));
      pl.delete();
      if (len <= MAXP) for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      pre.delete();
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        pre.push_back(8'($urandom));
        if (pre[i] == 8'hAA) pre[i] = 8'h12;
      end
      if ($urandom_range(0, 1) == 1) pre.push_back(8'hAA);
      run_frame("random", b, len, pl,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 255)) : 0, pre);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
